// File: rtl/fft_seq_pkg.sv
// Shared types and constants for the FFT column sequencer.
// The drain length keeps column c+1 from reading results column c has not written yet.
package fft_seq_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_e;

    localparam int NSLOT  = 4;
    localparam int SLOT_W = 2;
    localparam int COL_W  = 3;
    localparam int DRN_W  = 2;

    // Drain cycles between columns: at least one, otherwise the MAC latency.
    function automatic int drain_len(input int mac_lat);
        return (mac_lat > 1) ? mac_lat : 1;
    endfunction

endpackage

// File: rtl/fft_wr_delay.sv
// Delays the issue tuple {valid, col, slot} by LAT cycles to form the write strobe.
// LAT=0 is a pure pass-through; flush clears every stage on the next edge.
module fft_wr_delay
    import fft_seq_pkg::*;
#(
    parameter int LAT = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              flush,
    input  logic              in_valid,
    input  logic [COL_W-1:0]  in_col,
    input  logic [SLOT_W-1:0] in_slot,
    output logic              out_valid,
    output logic [COL_W-1:0]  out_col,
    output logic [SLOT_W-1:0] out_slot
);

    localparam int W = 1 + COL_W + SLOT_W;

    generate
        if (LAT == 0) begin : g_pass
            logic unused_pass;
            assign unused_pass = &{1'b0, clk, reset, flush};
            assign {out_valid, out_col, out_slot} = {in_valid, in_col, in_slot};
        end else begin : g_pipe
            logic [W-1:0] pipe_q [LAT];
            logic [W-1:0] pipe_d [LAT];

            always_comb begin
                for (int i = 0; i < LAT; i++) begin
                    pipe_d[i] = '0;
                end
                if (!flush) begin
                    pipe_d[0] = {in_valid, in_col, in_slot};
                    for (int i = 1; i < LAT; i++) begin
                        pipe_d[i] = pipe_q[i-1];
                    end
                end
            end

            always_ff @(posedge clk or negedge reset) begin
                if (!reset) begin
                    for (int i = 0; i < LAT; i++) begin
                        pipe_q[i] <= '0;
                    end
                end else begin
                    for (int i = 0; i < LAT; i++) begin
                        pipe_q[i] <= pipe_d[i];
                    end
                end
            end

            assign {out_valid, out_col, out_slot} = pipe_q[LAT-1];
        end
    endgenerate

endmodule

// File: rtl/fft_column_sequencer.sv
// Steps the shared 4-MAC column engine through all FFT columns, inserting
// drain bubbles between columns and ping-ponging the column buffers.
module fft_column_sequencer
    import fft_seq_pkg::*;
#(
    parameter int NCOL    = 5,
    parameter int MAC_LAT = 1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start_valid,
    output logic       start_ready,
    output logic       out_valid,
    input  logic       out_ready,
    input  logic       abort,
    output logic       busy,
    output logic       mac_en,
    output logic [1:0] mac_sel,
    output logic [2:0] col_sel,
    output logic       wr_en,
    output logic [2:0] wr_col,
    output logic [1:0] wr_slot,
    output logic       buf_sel
);

    localparam int                D         = drain_len(MAC_LAT);
    localparam logic [DRN_W-1:0]  DRN_LOAD  = DRN_W'(D - 1);
    localparam logic [COL_W-1:0]  COL_LAST  = COL_W'(NCOL - 1);
    localparam logic [SLOT_W-1:0] SLOT_LAST = SLOT_W'(NSLOT - 1);

    state_e              state_q, state_d;
    logic [COL_W-1:0]    col_q, col_d;
    logic [SLOT_W-1:0]   slot_q, slot_d;
    logic [DRN_W-1:0]    drn_q, drn_d;
    logic                buf_q, buf_d;
    logic                start_ready_q, start_ready_d;
    logic                out_valid_q, out_valid_d;
    logic                mac_en_q, mac_en_d;
    logic [SLOT_W-1:0]   mac_sel_q, mac_sel_d;
    logic [COL_W-1:0]    col_sel_q, col_sel_d;

    always_comb begin
        state_d = state_q;
        col_d   = col_q;
        slot_d  = slot_q;
        drn_d   = drn_q;
        buf_d   = buf_q;

        case (state_q)
            ST_IDLE: begin
                if (start_valid) begin
                    state_d = ST_ISSUE;
                    col_d   = '0;
                    slot_d  = '0;
                    buf_d   = 1'b0;
                end
            end
            ST_ISSUE: begin
                if (slot_q == SLOT_LAST) begin
                    state_d = ST_DRAIN;
                    slot_d  = '0;
                    drn_d   = DRN_LOAD;
                end else begin
                    slot_d = slot_q + 1'b1;
                end
            end
            ST_DRAIN: begin
                if (drn_q == '0) begin
                    if (col_q == COL_LAST) begin
                        state_d = ST_DONE;
                    end else begin
                        // Final column keeps buf_sel so it points at the result bank.
                        state_d = ST_ISSUE;
                        col_d   = col_q + 1'b1;
                        buf_d   = ~buf_q;
                    end
                end else begin
                    drn_d = drn_q - 1'b1;
                end
            end
            ST_DONE: begin
                if (out_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (abort) begin
            state_d = ST_IDLE;
            col_d   = '0;
            slot_d  = '0;
            drn_d   = '0;
            buf_d   = 1'b0;
        end

        // Outputs are registered from the next state so they line up with state_q.
        start_ready_d = (state_d == ST_IDLE);
        out_valid_d   = (state_d == ST_DONE);
        mac_en_d      = (state_d == ST_ISSUE);
        mac_sel_d     = mac_en_d ? slot_d : '0;
        col_sel_d     = mac_en_d ? col_d  : '0;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q       <= ST_IDLE;
            col_q         <= '0;
            slot_q        <= '0;
            drn_q         <= '0;
            buf_q         <= 1'b0;
            start_ready_q <= 1'b1;
            out_valid_q   <= 1'b0;
            mac_en_q      <= 1'b0;
            mac_sel_q     <= '0;
            col_sel_q     <= '0;
        end else begin
            state_q       <= state_d;
            col_q         <= col_d;
            slot_q        <= slot_d;
            drn_q         <= drn_d;
            buf_q         <= buf_d;
            start_ready_q <= start_ready_d;
            out_valid_q   <= out_valid_d;
            mac_en_q      <= mac_en_d;
            mac_sel_q     <= mac_sel_d;
            col_sel_q     <= col_sel_d;
        end
    end

    fft_wr_delay #(
        .LAT (MAC_LAT)
    ) u_wr_delay (
        .clk       (clk),
        .reset     (reset),
        .flush     (abort),
        .in_valid  (mac_en_q),
        .in_col    (col_sel_q),
        .in_slot   (mac_sel_q),
        .out_valid (wr_en),
        .out_col   (wr_col),
        .out_slot  (wr_slot)
    );

    assign start_ready = start_ready_q;
    assign out_valid   = out_valid_q;
    assign busy        = (state_q != ST_IDLE);
    assign mac_en      = mac_en_q;
    assign mac_sel     = mac_sel_q;
    assign col_sel     = col_sel_q;
    assign buf_sel     = buf_q;

endmodule
